serial_byte_receiver: RTL and testbench

SERIAL_BYTE_RECEIVER -- requirements
Module: serial_byte_receiver

---
 rtl/serial_byte_receiver.sv | 167 ++++++++++++++++
 tb/tb_serial_byte_receiver.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_byte_receiver.sv
// Asynchronous serial byte receiver with optional parity, framing/overrun
// flags, a single-byte holding register and a valid/ready consumer handshake.
module serial_byte_receiver #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200,
    parameter int PARITY    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_parity_err,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       rx_busy
);

    localparam int DIV  = CLK_FREQ / BAUD_RATE;
    localparam int HALF = DIV / 2;
    localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] SETTLE  = CW'(2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state, state_n;
    logic          sync1, rx_s;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          perr, perr_n;
    logic          deliver;
    logic          tick;

    assign tick = (cnt == DIV_M1);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            state   <= S_BREAK;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            perr    <= 1'b0;
        end else begin
            sync1   <= rx;
            rx_s    <= sync1;
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            perr    <= perr_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        perr_n    = perr;
        deliver   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_n = S_START;
                    cnt_n   = '0;
                end
            end
            S_START: begin
                if (cnt == HALF_M1) begin
                    cnt_n = '0;
                    if (!rx_s) begin
                        state_n   = S_DATA;
                        bit_idx_n = '0;
                        perr_n    = 1'b0;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shreg_n[bit_idx] = rx_s;
                    cnt_n            = '0;
                    bit_idx_n        = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_n = (PARITY != 0) ? S_PARITY : S_STOP;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_PARITY: begin
                if (tick) begin
                    perr_n  = ((^shreg) ^ rx_s) == (PARITY == 1);
                    cnt_n   = '0;
                    state_n = S_STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (tick) begin
                    deliver = 1'b1;
                    cnt_n   = '0;
                    state_n = rx_s ? S_IDLE : S_BREAK;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_BREAK: begin
                // let the synchronizer flush its reset value before trusting rx_s
                if (cnt != SETTLE) begin
                    cnt_n = cnt + 1'b1;
                end else if (rx_s) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = S_BREAK;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data       <= 8'h00;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
        end else if (deliver) begin
            if (rx_valid && !rx_ready) begin
                rx_overrun <= 1'b1;
            end else begin
                rx_data       <= shreg;
                rx_parity_err <= perr;
                rx_frame_err  <= ~rx_s;
                rx_valid      <= 1'b1;
            end
        end else if (rx_valid && rx_ready) begin
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end
    end

    assign rx_busy = (state == S_START) || (state == S_DATA) ||
                     (state == S_PARITY) || (state == S_STOP);

endmodule

// File: tb/tb_serial_byte_receiver.sv
// Scoreboard bench for serial_byte_receiver: frames are driven bit by bit,
// expected bytes are queued at send time and popped on each consume.
module tb_serial_byte_receiver;

    localparam int CLK_FREQ  = 25600000;
    localparam int BAUD_RATE = 100000;
    localparam int DIV       = CLK_FREQ / BAUD_RATE;
    localparam int HALF      = DIV / 2;
    // cycles from the start-bit drive to the cycle whose edge samples stop
    localparam int STOP_AT   = 2 + HALF + 10 * DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_parity_err;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    int checks = 0;
    int passes = 0;

    logic [9:0] sb[$];
    logic [9:0] exp_item;

    serial_byte_receiver #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE),
        .PARITY   (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_parity_err(rx_parity_err),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act,
                                  logic [31:0] want);
        checks++;
        if (act === want) passes++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    endfunction

    // even parity: error whenever data plus parity bit has odd weight
    function automatic void expect_byte(logic [7:0] d, logic pbit,
                                        logic stop);
        sb.push_back({d, (^d) ^ pbit, ~stop});
    endfunction

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(logic [7:0] d, logic pbit, logic stop);
        logic [10:0] bits;
        bits = {stop, pbit, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rx = bits[i];
            step(DIV);
        end
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_data"}, rx_data, 8'h00);
        check({tag, "_valid"}, rx_valid, 1'b0);
        check({tag, "_perr"}, rx_parity_err, 1'b0);
        check({tag, "_ferr"}, rx_frame_err, 1'b0);
        check({tag, "_ovr"}, rx_overrun, 1'b0);
        check({tag, "_busy"}, rx_busy, 1'b0);
    endtask

    always @(negedge clk) begin
        if (!rst && rx_valid && rx_ready) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_byte: got 0x%0h, want none",
                         rx_data);
            end else begin
                exp_item = sb.pop_front();
                check("sb_data", rx_data, exp_item[9:2]);
                check("sb_perr", rx_parity_err, exp_item[1]);
                check("sb_ferr", rx_frame_err, exp_item[0]);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        logic       bad;

        rst      = 1'b1;
        rx       = 1'b1;
        rx_ready = 1'b0;
        step(3);
        check_reset_outputs("rst");
        rst = 1'b0;
        step(5);

        // 0x55, correct even parity, latency around the stop sample
        expect_byte(8'h55, 1'b0, 1'b1);
        fork
            send(8'h55, 1'b0, 1'b1);
            begin
                step(STOP_AT);
                check("lat_pre", rx_valid, 1'b0);
                step(1);
                check("lat_post", rx_valid, 1'b1);
            end
        join
        check("t55_data", rx_data, 8'h55);
        check("t55_perr", rx_parity_err, 1'b0);
        check("t55_ferr", rx_frame_err, 1'b0);
        consume();
        check("t55_drop", rx_valid, 1'b0);

        // 0xA3 with wrong parity bit
        expect_byte(8'hA3, 1'b1, 1'b1);
        send(8'hA3, 1'b1, 1'b1);
        check("tA3_data", rx_data, 8'hA3);
        check("tA3_perr", rx_parity_err, 1'b1);
        check("tA3_ferr", rx_frame_err, 1'b0);
        consume();

        // short low pulse is rejected as a glitch
        rx = 1'b0;
        step(50);
        check("glitch_busy", rx_busy, 1'b1);
        step(50);
        rx = 1'b1;
        step(HALF - 100 + 10);
        check("glitch_idle", rx_busy, 1'b0);
        check("glitch_valid", rx_valid, 1'b0);
        rx_ready = 1'b1;
        expect_byte(8'h0F, 1'b0, 1'b1);
        send(8'h0F, 1'b0, 1'b1);
        step(5);

        // framing error followed by a long break
        expect_byte(8'h3C, 1'b0, 1'b0);
        send(8'h3C, 1'b0, 1'b0);
        step(2000);
        check("brk_busy", rx_busy, 1'b0);
        check("brk_sb", sb.size(), 0);
        rx = 1'b1;
        step(10);
        expect_byte(8'h81, 1'b0, 1'b1);
        send(8'h81, 1'b0, 1'b1);
        step(5);
        check("t81_sb", sb.size(), 0);

        // overrun: second byte lost while first is held
        rx_ready = 1'b0;
        expect_byte(8'h11, 1'b0, 1'b1);
        send(8'h11, 1'b0, 1'b1);
        send(8'h22, 1'b0, 1'b1);
        step(2);
        check("ovr_data", rx_data, 8'h11);
        check("ovr_valid", rx_valid, 1'b1);
        check("ovr_flag", rx_overrun, 1'b1);
        consume();
        check("ovr_drop", rx_valid, 1'b0);
        check("ovr_clr", rx_overrun, 1'b0);

        // consume coinciding with the next delivery
        expect_byte(8'h11, 1'b0, 1'b1);
        send(8'h11, 1'b0, 1'b1);
        expect_byte(8'h22, 1'b0, 1'b1);
        fork
            send(8'h22, 1'b0, 1'b1);
            begin
                step(STOP_AT);
                rx_ready = 1'b1;
                step(1);
                rx_ready = 1'b0;
            end
        join
        check("same_valid", rx_valid, 1'b1);
        check("same_data", rx_data, 8'h22);
        check("same_ovr", rx_overrun, 1'b0);
        consume();

        // reset in the middle of bit 4 with the line held low
        rx_ready = 1'b1;
        rx       = 1'b0;
        step(3 + HALF + 4 * DIV + DIV / 2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_reset_outputs("mid");
        step(3 * DIV);
        check("mid_valid", rx_valid, 1'b0);
        check("mid_busy", rx_busy, 1'b0);
        rx = 1'b1;
        step(2 * DIV);
        expect_byte(8'h5A, 1'b0, 1'b1);
        send(8'h5A, 1'b0, 1'b1);
        step(5);

        // random bytes, occasionally with a corrupted parity bit
        for (int i = 0; i < 6; i++) begin
            d   = 8'($urandom);
            bad = ($urandom_range(0, 2) == 0);
            expect_byte(d, (^d) ^ bad, 1'b1);
            send(d, (^d) ^ bad, 1'b1);
            step($urandom_range(1, 20));
        end

        step(20);
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
